// File: rtl/risc_run_controller_pkg.sv
// risc_ctrl_pkg: shared types for the RISC run/load controller.
//   ctrl_state_t   - controller FSM states
//   LOAD_SEL_*     - load target select encoding (instruction / data memory)
//   ctrl_flags_t   - bundle of the registered status/control outputs
//   state_flags()  - output values that belong to each state
package risc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CORE_RST,
        ST_RUN,
        ST_HALTED,
        ST_TIMEOUT
    } ctrl_state_t;

    localparam logic LOAD_SEL_INSTR = 1'b0;
    localparam logic LOAD_SEL_DATA  = 1'b1;

    typedef struct packed {
        logic core_clr;
        logic test_normal;
        logic busy;
        logic done;
        logic timeout;
    } ctrl_flags_t;

    // Held while the controller itself is in reset: core held in reset,
    // memories on the external side.
    localparam ctrl_flags_t RESET_FLAGS = '{
        core_clr:    1'b0,
        test_normal: 1'b1,
        busy:        1'b0,
        done:        1'b0,
        timeout:     1'b0
    };

    // The registered outputs are a pure function of the state being entered,
    // so every transition loads them from here.
    function automatic ctrl_flags_t state_flags(input ctrl_state_t s);
        ctrl_flags_t f;
        f.core_clr    = (s != ST_CORE_RST);
        f.test_normal = !((s == ST_CORE_RST) || (s == ST_RUN));
        f.busy        = (s == ST_LOAD) || (s == ST_CORE_RST) || (s == ST_RUN);
        f.done        = (s == ST_HALTED) || (s == ST_TIMEOUT);
        f.timeout     = (s == ST_TIMEOUT);
        return f;
    endfunction

endpackage

// File: rtl/risc_run_controller_if.sv
// risc_run_controller_if: burst-load stream between host and controller.
//   load_begin/load_sel/load_base - open a burst (target memory, first address)
//   load_valid/load_ready         - beat handshake
//   load_last/load_data           - final-beat marker and beat payload
// Modports: master = host side, slave = controller side.
interface risc_run_controller_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              load_begin;
    logic              load_sel;
    logic [ADDR_W-1:0] load_base;
    logic              load_valid;
    logic              load_last;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;

    modport master (
        output load_begin, load_sel, load_base, load_valid, load_last, load_data,
        input  load_ready
    );

    modport slave (
        input  load_begin, load_sel, load_base, load_valid, load_last, load_data,
        output load_ready
    );
endinterface

// File: rtl/risc_run_controller_load_addr_gen.sv
// risc_load_addr_gen: address counter and write stage for memory bursts.
//   clk, rst_n        - clock, asynchronous active-low reset
//   open_burst        - load counter from open_base and latch open_sel
//   beat              - accepted beat: write now, then advance counter
//   beat_data         - beat payload
//   instr_we/data_we  - one-cycle write strobes, one cycle after the beat
//   addr/wdata        - registered write address and data
module risc_load_addr_gen
    import risc_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              open_burst,
    input  logic              open_sel,
    input  logic [ADDR_W-1:0] open_base,
    input  logic              beat,
    input  logic [DATA_W-1:0] beat_data,
    output logic              instr_we,
    output logic              data_we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata
);

    logic [ADDR_W-1:0] addr_cnt;
    logic              target_sel;

    // Burst address counter; the add simply overflows so the top address
    // wraps to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt   <= '0;
            target_sel <= LOAD_SEL_INSTR;
        end else if (open_burst) begin
            addr_cnt   <= open_base;
            target_sel <= open_sel;
        end else if (beat) begin
            addr_cnt   <= addr_cnt + 1'b1;
        end
    end

    // Write stage: strobes last one cycle; address/data hold between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_we <= 1'b0;
            data_we  <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
        end else begin
            instr_we <= beat && (target_sel == LOAD_SEL_INSTR);
            data_we  <= beat && (target_sel == LOAD_SEL_DATA);
            if (beat) begin
                addr  <= addr_cnt;
                wdata <= beat_data;
            end
        end
    end

endmodule

// File: rtl/risc_run_controller.sv
// risc_run_controller: load/reset/run sequencer for the single-cycle RISC core.
//   clk, clr          - clock, asynchronous active-low reset
//   load_if (slave)   - burst-load stream into instruction or data memory
//   start             - reset the core and run (from IDLE/HALTED/TIMEOUT)
//   step_mode, step   - single-step level and per-instruction pulse
//   abort             - return to IDLE from any state
//   core_halt         - HLT decoded by the core
//   core_clr          - active-low core reset
//   core_run_en       - core advance enable (combinational)
//   test_normal       - 1 = memories on external side, 0 = core owns them
//   ext_instr_we/ext_data_we/ext_addr/ext_wdata - memory write port
//   cycle_count       - enabled cycles this run (saturating)
//   busy/done/timeout - status
// Optional feature: define WATCHDOG_EN to stop a run at WDOG_LIMIT cycles.
module risc_run_controller
    import risc_ctrl_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 2,
    parameter int WDOG_LIMIT = 65535
) (
    input  logic                 clk,
    input  logic                 clr,
    risc_run_controller_if.slave load_if,
    input  logic                 start,
    input  logic                 step_mode,
    input  logic                 step,
    input  logic                 abort,
    input  logic                 core_halt,
    output logic                 core_clr,
    output logic                 core_run_en,
    output logic                 test_normal,
    output logic                 ext_instr_we,
    output logic                 ext_data_we,
    output logic [ADDR_W-1:0]    ext_addr,
    output logic [DATA_W-1:0]    ext_wdata,
    output logic [CNT_W-1:0]     cycle_count,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout
);

    localparam int               RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

    ctrl_state_t      state;
    ctrl_flags_t      flags;
    logic [RST_W-1:0] rst_cnt;
    logic             can_open;
    logic             open_burst;
    logic             ready_int;
    logic             beat;
    logic             wdog_hit;

    assign can_open   = (state == ST_IDLE) || (state == ST_HALTED) || (state == ST_TIMEOUT);
    assign open_burst = can_open && load_if.load_begin && !abort;

    // Ready drops during abort so a beat offered in that cycle never
    // completes the handshake.
    assign ready_int          = (state == ST_LOAD) && !abort;
    assign load_if.load_ready = ready_int;
    assign beat               = ready_int && load_if.load_valid;

    // Abort also gates the enable so the count is frozen in the abort cycle.
    assign core_run_en = (state == ST_RUN) && !abort && !core_halt && (!step_mode || step);

    assign core_clr    = flags.core_clr;
    assign test_normal = flags.test_normal;
    assign busy        = flags.busy;
    assign done        = flags.done;

`ifdef WATCHDOG_EN
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_LIMIT - 1);

    // Fires on the enabled cycle that brings the count to WDOG_LIMIT, so the
    // run stops with exactly WDOG_LIMIT cycles executed.
    assign wdog_hit = core_run_en && (cycle_count >= WDOG_LAST);
    assign timeout  = flags.timeout;
`else
    logic unused_wdog;

    assign wdog_hit    = 1'b0;
    assign timeout     = 1'b0;
    assign unused_wdog = (WDOG_LIMIT != 0) ^ flags.timeout;
`endif

    // Controller FSM. Registered outputs follow the state being entered via
    // state_flags(); the first assignment keeps them in step with the current
    // state and is overridden on every transition.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= ST_IDLE;
            flags       <= RESET_FLAGS;
            rst_cnt     <= '0;
            cycle_count <= '0;
        end else begin
            flags <= state_flags(state);
            if (abort) begin
                state <= ST_IDLE;
                flags <= state_flags(ST_IDLE);
            end else begin
                case (state)
                    ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
                        if (load_if.load_begin) begin
                            state <= ST_LOAD;
                            flags <= state_flags(ST_LOAD);
                        end else if (start) begin
                            state       <= ST_CORE_RST;
                            flags       <= state_flags(ST_CORE_RST);
                            rst_cnt     <= '0;
                            cycle_count <= '0;
                        end
                    end
                    ST_LOAD: begin
                        if (beat && load_if.load_last) begin
                            state <= ST_IDLE;
                            flags <= state_flags(ST_IDLE);
                        end
                    end
                    ST_CORE_RST: begin
                        if (rst_cnt == RST_LAST) begin
                            state <= ST_RUN;
                            flags <= state_flags(ST_RUN);
                        end else begin
                            rst_cnt <= rst_cnt + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (core_run_en && (cycle_count != '1)) begin
                            cycle_count <= cycle_count + 1'b1;
                        end
                        if (core_halt) begin
                            state <= ST_HALTED;
                            flags <= state_flags(ST_HALTED);
                        end else if (wdog_hit) begin
                            state <= ST_TIMEOUT;
                            flags <= state_flags(ST_TIMEOUT);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        flags <= state_flags(ST_IDLE);
                    end
                endcase
            end
        end
    end

    risc_load_addr_gen #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (clr),
        .open_burst (open_burst),
        .open_sel   (load_if.load_sel),
        .open_base  (load_if.load_base),
        .beat       (beat),
        .beat_data  (load_if.load_data),
        .instr_we   (ext_instr_we),
        .data_we    (ext_data_we),
        .addr       (ext_addr),
        .wdata      (ext_wdata)
    );

endmodule
